// File: rtl/csr_decode_if.sv
// Sparse-entry in / dense-pixel out handshake bundle for csr_decode.
// master = upstream/downstream driver, slave = the decoder.
interface csr_decode_if #(
  parameter int col_length         = 8,
  parameter int word_length        = 8,
  parameter int double_word_length = 16
);
  logic                          start;
  logic [double_word_length-1:0] nnz_in;
  logic                          in_valid;
  logic                          in_ready;
  logic [word_length-1:0]        in_value;
  logic [col_length-1:0]         in_col;
  logic [col_length-1:0]         in_row;
  logic                          out_valid;
  logic                          out_ready;
  logic [word_length-1:0]        out_data;
  logic                          out_last;
  logic                          done;
  logic                          err;

  modport master (
    output start, nnz_in, in_valid, in_value, in_col, in_row, out_ready,
    input  in_ready, out_valid, out_data, out_last, done, err
  );

  modport slave (
    input  start, nnz_in, in_valid, in_value, in_col, in_row, out_ready,
    output in_ready, out_valid, out_data, out_last, done, err
  );
endinterface

// File: rtl/csr_decode.sv
// Sparse (value,col,row) stream to dense raster-order frame decoder.
// CSR_DEC_ORDER_CHECK_EN: invalid entries raise sticky err and park in ERROR; otherwise they are dropped.
module csr_decode #(
  parameter int col_length         = 8,
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 28
) (
  input  logic         clk,
  input  logic         rst,
  csr_decode_if.slave  bus
);
  localparam int DW = double_word_length;
  localparam logic [DW-1:0]         NPIX  = DW'(image_size * image_size);
  localparam logic [DW-1:0]         LASTP = NPIX - 1'b1;
  localparam logic [DW-1:0]         IMG_D = DW'(image_size);
  localparam logic [col_length-1:0] IMG_C = col_length'(image_size);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_t;

  state_t                 state_q;
  logic [DW-1:0]          cnt_q, rem_q, hold_idx_q;
  logic                   hold_valid_q, hold_bad_q;
  logic [word_length-1:0] hold_val_q;

  logic          emit, hold_inv, hit, out_hs, in_hs, hold_consumed, drop, to_err;
  logic [DW-1:0] idx_in;
  logic          bad_in;

  assign emit     = (state_q == EMIT);
  // A held entry is unusable if it lies behind the raster position or outside the image.
  assign hold_inv = hold_valid_q && (hold_bad_q || (hold_idx_q < cnt_q));
  assign hit      = hold_valid_q && !hold_bad_q && (hold_idx_q == cnt_q);

  assign bus.out_valid = emit && ((hold_valid_q && !hold_inv) || (rem_q == '0 && !hold_valid_q));
  assign bus.out_data  = (bus.out_valid && hit) ? hold_val_q : '0;
  assign bus.out_last  = bus.out_valid && (cnt_q == LASTP);
  assign bus.done      = (state_q == DONE);

`ifdef CSR_DEC_ORDER_CHECK_EN
  assign drop    = 1'b0;
  assign to_err  = emit && hold_inv;
  assign bus.err = (state_q == ERROR);
`else
  assign drop    = hold_inv;
  assign to_err  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign out_hs        = bus.out_valid && bus.out_ready;
  assign hold_consumed = emit && ((out_hs && hit) || drop);
  assign bus.in_ready  = emit && (!hold_valid_q || hold_consumed) && (rem_q != '0);
  assign in_hs         = bus.in_valid && bus.in_ready;

  assign idx_in = DW'(bus.in_row) * IMG_D + DW'(bus.in_col);
  assign bad_in = (bus.in_col >= IMG_C) || (bus.in_row >= IMG_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_bad_q   <= 1'b0;
      hold_idx_q   <= '0;
      hold_val_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          rem_q        <= bus.nnz_in;
          cnt_q        <= '0;
          hold_valid_q <= 1'b0;
          state_q      <= EMIT;
        end
        EMIT: if (to_err) begin
          state_q <= ERROR;
        end else begin
          if (out_hs) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LASTP) state_q <= DONE;
          end
          // Load wins over consume: a new entry may refill the slot the same cycle it empties.
          if (in_hs) begin
            hold_valid_q <= 1'b1;
            hold_idx_q   <= idx_in;
            hold_bad_q   <= bad_in;
            hold_val_q   <= bus.in_value;
            rem_q        <= rem_q - 1'b1;
          end else if (hold_consumed) begin
            hold_valid_q <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_decode.sv
// Frame-level bench for csr_decode: table of sparse frames, scoreboard of expected dense pixels.
module tb_csr_decode;
  localparam int CL = 8, WL = 8, DW = 16, IS = 28, N = IS * IS;
`ifdef CSR_DEC_ORDER_CHECK_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_decode_if #(.col_length(CL), .word_length(WL), .double_word_length(DW)) bus();
  csr_decode #(.col_length(CL), .word_length(WL), .double_word_length(DW), .image_size(IS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int              nnz;
    logic [2:0][7:0] col;
    logic [2:0][7:0] row;
    logic [2:0][7:0] val;
    bit              tog;
    int              exp_hs;
    bit              exp_err;
  } vec_t;

  int total = 0, bad = 0;
  logic [WL-1:0] expq[$];
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int nnz,
      input int c0, r0, v0, c1, r1, v1, c2, r2, v2,
      input bit tog, input int ehs, input bit eerr);
    vec_t v;
    v.nnz = nnz; v.tog = tog; v.exp_hs = ehs; v.exp_err = eerr;
    v.col[0] = 8'(c0); v.row[0] = 8'(r0); v.val[0] = 8'(v0);
    v.col[1] = 8'(c1); v.row[1] = 8'(r1); v.val[1] = 8'(v1);
    v.col[2] = 8'(c2); v.row[2] = 8'(r2); v.val[2] = 8'(v2);
    return v;
  endfunction

  // Reference image: entries must be in range and strictly ahead of the raster position.
  task automatic push_frame(input vec_t v);
    logic [WL-1:0] img[N];
    int pos = 0;
    for (int p = 0; p < N; p++) img[p] = '0;
    for (int i = 0; i < v.nnz; i++) begin
      int idx = int'(v.row[i]) * IS + int'(v.col[i]);
      if (v.col[i] < IS && v.row[i] < IS && idx >= pos) begin
        img[idx] = v.val[i];
        pos = idx + 1;
      end
    end
    for (int p = 0; p < N; p++) expq.push_back(img[p]);
  endtask

  task automatic run_frame(input vec_t v, input int abort_at,
      output int hs, output int ei, output int gaps, output bit done_seen, output bit err_seen);
    logic [WL-1:0] stall_d = '0, e;
    bit stall_pend = 1'b0;
    hs = 0; ei = 0; gaps = 0; done_seen = 1'b0; err_seen = 1'b0;
    bus.start = 1'b1; bus.nnz_in = DW'(v.nnz);
    push_frame(v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.in_valid = (ei < v.nnz);
      if (ei < 3) begin
        bus.in_col = v.col[ei]; bus.in_row = v.row[ei]; bus.in_value = v.val[ei];
      end
      bus.out_ready = v.tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("first_valid_latency", 32'(bus.out_valid), 32'(v.nnz == 0));
      if (stall_pend) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(stall_d));
        stall_pend = 1'b0;
      end
      if (bus.err)  begin err_seen = 1'b1;  break; end
      if (bus.done) begin done_seen = 1'b1; break; end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_pixel", 32'(hs), 32'(N)); e = '0;
        end else e = expq.pop_front();
        chk($sformatf("pixel_%0d", hs), 32'(bus.out_data), 32'(e));
        chk("out_last", 32'(bus.out_last), 32'(hs == N - 1));
        hs++;
        if (abort_at >= 0 && hs == abort_at) break;
      end else if (bus.out_valid) begin
        stall_pend = 1'b1; stall_d = bus.out_data;
      end else if (!v.tog && v.nnz == 0 && hs > 0) gaps++;
      if (bus.in_valid && bus.in_ready) ei++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  initial begin
    int hs, ei, gaps;
    bit dn, er;
    vt[0] = mk(0, 0,0,0, 0,0,0, 0,0,0, 1'b0, N, 1'b0);
    vt[1] = mk(2, 3,0,8'h5A, 0,27,8'h11, 0,0,0, 1'b0, N, 1'b0);
    vt[2] = mk(2, 3,0,8'h5A, 0,27,8'h11, 0,0,0, 1'b1, N, 1'b0);
    vt[3] = mk(2, 5,0,8'h01, 2,0,8'h02, 0,0,0, 1'b0, ORD ? 6 : N, ORD);
    vt[4] = mk(3, 0,0,8'h00, 10,1,8'h33, 27,27,8'hFF, 1'b1, N, 1'b0);
    vt[5] = mk(1, 28,0,8'h77, 0,0,0, 0,0,0, 1'b0, ORD ? 0 : N, ORD);
    vt[6] = mk(2, 4,2,8'h10, 4,2,8'h20, 0,0,0, 1'b0, ORD ? 61 : N, ORD);

    bus.start = 0; bus.nnz_in = '0; bus.in_valid = 0; bus.in_value = '0;
    bus.in_col = '0; bus.in_row = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    #1 check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      run_frame(vt[t], -1, hs, ei, gaps, dn, er);
      chk($sformatf("v%0d_handshakes", t), 32'(hs), 32'(vt[t].exp_hs));
      chk($sformatf("v%0d_err", t), 32'(er), 32'(vt[t].exp_err));
      chk($sformatf("v%0d_done", t), 32'(dn), 32'(!vt[t].exp_err));
      if (vt[t].exp_err) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("err_sticky", 32'(bus.err), 32'd1);
          chk("err_no_valid", 32'({bus.out_valid, bus.in_ready}), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        expq.delete();
      end else begin
        chk($sformatf("v%0d_entries_taken", t), 32'(ei), 32'(vt[t].nnz));
        chk($sformatf("v%0d_queue_empty", t), 32'(expq.size()), 32'd0);
        if (vt[t].nnz == 0 && !vt[t].tog) chk("zero_frame_gaps", 32'(gaps), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
      end
      @(posedge clk); #1;
    end

    // Abort mid-frame, then confirm no resume and a clean fresh frame.
    run_frame(vt[0], 100, hs, ei, gaps, dn, er);
    chk("abort_hs", 32'(hs), 32'd100);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_idle_outputs("midframe_rst");
    @(posedge clk); #1 rst = 1'b0;
    expq.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_resume", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_frame(vt[0], -1, hs, ei, gaps, dn, er);
    chk("post_rst_hs", 32'(hs), 32'(N));
    chk("post_rst_done", 32'(dn), 32'd1);
    chk("post_rst_gaps", 32'(gaps), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_decode.md
CSR_DECODE -- requirements
Module: csr_decode

Interface
REQ-001 Parameter col_length, default 8, width of column/row index fields.
REQ-002 Parameter word_length, default 8, pixel/value width.
REQ-003 Parameter double_word_length, default 16, width of pixel counter and entry counts.
REQ-004 Parameter image_size, default 28, image edge; frame holds N = image_size*image_size pixels.
REQ-005 Port clk  input  1  sole clock; all state on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port start  input  1  frame start pulse, sampled in IDLE only.
REQ-008 Port nnz_in  input  double_word_length  number of sparse entries for the frame, sampled with start.
REQ-009 Port in_valid  input  1  sparse entry present.
REQ-010 Port in_ready  output  1  decoder accepts entry this cycle.
REQ-011 Port in_value / in_col / in_row  input  word_length / col_length / col_length  entry value, column, row.
REQ-012 Port out_valid  output  1  dense pixel present.
REQ-013 Port out_ready  input  1  downstream accepts pixel.
REQ-014 Port out_data  output  word_length  dense pixel, raster order (row-major).
REQ-015 Port out_last  output  1  high with pixel N-1.
REQ-016 Port done  output  1  one-cycle pulse after frame completes.
REQ-017 Port err  output  1  sticky error flag.

Function
REQ-018 States SHALL be IDLE, EMIT, DONE, ERROR, 2-bit encoded.
REQ-019 IDLE: start=1 SHALL latch remaining=nnz_in, pixel counter=0, go EMIT next cycle; start outside IDLE SHALL be ignored.
REQ-020 Single-entry hold register: in_ready = (state==EMIT) && (!hold_valid || hold_consumed) && remaining!=0; entry transfers when in_valid && in_ready, remaining decrements by 1.
REQ-021 Entry linear index SHALL be in_row*image_size + in_col, computed in double_word_length bits.
REQ-022 EMIT: out_valid SHALL be 1 when hold_valid and hold index >= counter, or when remaining==0 and !hold_valid; otherwise 0 (waiting for next entry).
REQ-023 out_data SHALL equal hold value when hold index == counter, else 0; a matching hold entry is consumed on the out handshake.
REQ-024 Counter SHALL increment on each out_valid && out_ready; out_data/out_valid SHALL hold stable while out_ready=0.
REQ-025 Handshake of pixel N-1 SHALL move EMIT->DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 Zero-valued entries SHALL be accepted and emitted as 0 without error.
REQ-027 Start-to-first-pixel latency: start at cycle t, entry offered at t+1 -> out_valid earliest at t+2; with nnz_in=0, out_valid at t+1 and one pixel per cycle thereafter.
REQ-028 Invalid entry: hold index < counter (out-of-order/duplicate), or in_col/in_row >= image_size; handling per Configuration.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter=0, remaining=0, hold_valid=0, out_valid=0, out_data=0, out_last=0, in_ready=0, done=0, err=0, regardless of frame progress.
REQ-030 Frame aborted by reset SHALL not resume; a new start is required.

Configuration
REQ-031 Macro CSR_DEC_ORDER_CHECK_EN defined: invalid entry SHALL set err=1, go ERROR, deassert in_ready/out_valid until reset.
REQ-032 Macro undefined: invalid entry SHALL be dropped (consumed without emission, one cycle with out_valid=0), err tied 0, ERROR unreachable.

Verification
REQ-033 start, nnz_in=0, out_ready=1 -> 784 zero pixels on 784 consecutive cycles, out_last on 784th, done pulse next cycle.
REQ-034 nnz_in=2, entries (col3,row0,0x5A),(col0,row27,0x11) -> pixel 3=0x5A, pixel 756=0x11, all others 0.
REQ-035 Same as REQ-034 with out_ready toggling 1/0 each cycle -> identical pixel sequence, out_data stable during stall, 784 handshakes total.
REQ-036 Entries (col5,row0,0x01) then (col2,row0,0x02): with CSR_DEC_ORDER_CHECK_EN -> err=1 after pixel 5, no further out_valid; without -> second entry dropped, pixel 2=0, frame completes, err=0.
REQ-037 rst asserted after 100 pixels -> all outputs 0 same cycle; new start with nnz_in=0 -> full 784-pixel zero frame.
